// File: rtl/throttled_check_sink.sv
// Receive-end stream checker: compares each accepted message against an expected memory,
// throttles rdy with a Galois LFSR and flags a stall via an idle watchdog.
module throttled_check_sink #(
  parameter int          p_width    = 16,
  parameter int          p_n_msgs   = 108,
  parameter int          p_throttle = 1,
  parameter logic [15:0] p_seed     = 16'hACE1,
  parameter int          p_timeout  = 1024,
  localparam int         IDXW       = (p_n_msgs > 1) ? $clog2(p_n_msgs) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ld_en,
  input  logic [IDXW-1:0]    ld_idx,
  input  logic [p_width-1:0] ld_data,
  input  logic               val,
  output logic               rdy,
  input  logic [p_width-1:0] msg,
  output logic               done,
  output logic               pass,
  output logic               timeout,
  output logic [7:0]         err_count,
  output logic [IDXW-1:0]    err_idx
);

  localparam int TW = $clog2(p_timeout);

  typedef enum logic [1:0] {S_RUN, S_DONE, S_TIMEOUT} state_t;

  state_t             r_state;
  logic [IDXW-1:0]    r_idx;
  logic [15:0]        r_lfsr;
  logic [TW-1:0]      r_idle;
  logic [7:0]         r_err_count;
  logic [IDXW-1:0]    r_err_idx;
  logic               r_first_err;
  logic [p_width-1:0] r_mem [p_n_msgs];

  logic               w_rdy;
  logic               w_fire;
  logic               w_mismatch;
  logic               w_last;
  logic               w_expire;
  logic [15:0]        w_lfsr_next;

  assign w_rdy       = (r_state == S_RUN) && ((p_throttle == 0) || (r_lfsr[1:0] != 2'b00));
  assign w_fire      = val && w_rdy;
  assign w_mismatch  = (msg != r_mem[r_idx]);
  assign w_last      = (r_idx == IDXW'(p_n_msgs - 1));
  assign w_expire    = (r_idle == TW'(p_timeout - 1));
  assign w_lfsr_next = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);

  // Non-blocking write gives read-before-write against the same-cycle compare.
  always_ff @(posedge clk) begin
    if (ld_en && ({1'b0, ld_idx} < (IDXW+1)'(p_n_msgs))) begin
      r_mem[ld_idx] <= ld_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_RUN;
      r_idx       <= '0;
      r_lfsr      <= p_seed;
      r_idle      <= '0;
      r_err_count <= 8'd0;
      r_err_idx   <= '1;
      r_first_err <= 1'b0;
    end else if (r_state == S_RUN) begin
      r_lfsr <= w_lfsr_next;
      if (w_fire) begin
        r_idle <= '0;
        // idx freezes on the final message rather than wrapping.
        if (w_last) r_state <= S_DONE;
        else        r_idx   <= r_idx + IDXW'(1);
        if (w_mismatch) begin
          if (r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
          if (!r_first_err) begin
            r_first_err <= 1'b1;
            r_err_idx   <= r_idx;
          end
        end
      end else if (w_expire) begin
        r_state <= S_TIMEOUT;
      end else begin
        r_idle <= r_idle + TW'(1);
      end
    end
  end

  assign rdy       = w_rdy;
  assign done      = (r_state == S_DONE);
  assign timeout   = (r_state == S_TIMEOUT);
  assign pass      = (r_state == S_DONE) && (r_err_count == 8'd0);
  assign err_count = r_err_count;
  assign err_idx   = r_err_idx;

endmodule
